hsv_core_flush_seq: RTL and testbench
=====================================

# hsv_core_flush_seq

Flush sequencer for the hsv_core pipeline. It accepts redirect requests from two prioritized sources: source 0 is trap/exception entry, source 1 is redirect (mode return, branch). It broadcasts one pipeline-wide flush with a held target PC and collects per-stage flush acknowledgements until every stage has drained. It then releases the flush and signals completion. It sits between the commit/control-status logic that raises redirects and the fetch, decode, issue, execution-unit and commit stages that consume `flush_req`/`flush_target`.

## Interface
Parameters:
- `NUM_ACKS`, default 8: number of stages acknowledging a flush (fetch, decode, issue, alu, foo, mem, branch, commit).
- `TIMEOUT`, default 1024: cycles in FLUSH without full acknowledgement before `flush_timeout` is set; range 2..65535.

Ports:
- `clk_core`, in, 1: core clock; all state changes on its rising edge.
- `rst_core`, in, 1: one clock; reset is asynchronous and active-high.
- `req_valid`, in, 2: per-source redirect request; bit 0 = trap (highest priority), bit 1 = redirect.
- `req_target`, in, 2x32 (`word`): per-source redirect PC.
- `req_ready`, out, 2: per-source acceptance; transfer when `req_valid[i] && req_ready[i]`.
- `flush_ack`, in, NUM_ACKS: per-stage acknowledgement, level or pulse.
- `flush_req`, out, 1: flush broadcast to all stages.
- `flush_target`, out, 32: PC to resume from; stable while `flush_req`=1.
- `flush_src`, out, 1: source currently being served.
- `flush_busy`, out, 1: high in states FLUSH and DONE.
- `flush_done`, out, 1: one-cycle completion pulse.
- `flush_timeout`, out, 1: sticky error flag.

## Operation
- States: IDLE, FLUSH, DONE.
- **IDLE**
  - `req_ready[0]=1`; `req_ready[1]=!req_valid[0]`.
  - On a transfer from source i: latch `req_target[i]` into `flush_target`, set `flush_src=i`, clear the ack mask and timeout counter, and go to FLUSH.
- **FLUSH**
  - `flush_req=1`.
  - Each cycle: `ack_mask |= flush_ack`. Acks on the current cycle count toward completion.
  - When `(ack_mask | flush_ack)` is all ones, go to DONE.
  - Preemption: while serving source 1, `req_ready[0]=1`. A source-0 transfer replaces `flush_target`, sets `flush_src=0`, clears `ack_mask` (acks in that cycle are discarded), and clears the counter. `flush_req` stays high.
  - Preemption takes priority over completion in the same cycle.
  - While serving source 0, `req_ready=2'b00`. Source 1 is never accepted outside IDLE.
- **Timeout counter** (16-bit)
  - Increments each FLUSH cycle and saturates.
  - When it reaches `TIMEOUT-1` without the completion condition, `flush_timeout` is set. It is cleared only by reset.
  - The sequencer keeps waiting; no forced release.
- **DONE**
  - `flush_req=0` and `flush_done=1` for exactly this one cycle.
  - `req_ready=0`; `flush_target` and `flush_src` are held. Next state is IDLE.
- Acks outside FLUSH are ignored.
- Reset asserted at any time, including mid-flush: state goes to IDLE immediately.
  - Outputs: `flush_req=0`, `flush_target=0`, `flush_src=0`, `flush_busy=0`, `flush_done=0`, `flush_timeout=0`.
  - Internal: `ack_mask=0`, counter=0.
  - `req_ready` then follows the IDLE rule.

## Timing
- `req_ready` is combinational from state and `req_valid`. All other outputs are registered.
- Request accepted at cycle t:
  - `flush_req`, `flush_busy` and the new `flush_target` are visible at t+1.
- Last missing ack sampled at cycle n (n ≥ t+1):
  - DONE at n+1 (`flush_req=0`, `flush_done=1`, `flush_busy=1`).
  - IDLE at n+2; the next request can be accepted at n+2.
- Minimum turnaround: all acks high at t+1 gives `flush_done` at t+2 and the next accept at t+3.
- Preemption accepted at cycle p: the new `flush_target` is visible at p+1, and completion requires a full ack set sampled at ≥ p+1.
- Timeout: with no completion from first FLUSH cycle f, `flush_timeout` rises at f+TIMEOUT.

## Test plan
- **Basic flush.** Reset, then `req_valid=2'b10`, `req_target[1]=0x0000_1000` at cycle 1.
  - Required: `req_ready[1]=1` at cycle 1; `flush_req=1`, `flush_target=0x1000` at cycle 2.
  - Drive acks 0..7 as single pulses on cycles 3..10: `flush_done` at 11, `flush_req` low at 11, IDLE at 12.
- **Priority.** Both valid in IDLE with targets 0x8000_0000 and 0x2000.
  - Required: only `req_ready[0]=1`; `flush_target=0x8000_0000`, `flush_src=0`. Source 1 stays pending and is accepted at the first IDLE cycle after `flush_done`.
- **Preemption.** Serving source 1 (target 0x2000) with acks 0..3 received, raise source 0 (target 0x8000_0004).
  - Required: target switches the next cycle and `flush_req` never drops.
  - Re-driving acks 4..7 alone does not complete; acks 0..7 must all arrive again.
- **Ack edge cases.**
  - All eight acks held high before the request: `flush_done` two cycles after the accept.
  - Acks in IDLE/DONE have no effect on the next flush.
- **Timeout.** `TIMEOUT=8`, ack 7 withheld.
  - Required: `flush_timeout` rises 8 cycles after the first FLUSH cycle and stays high; late ack 7 completes the flush normally; flag remains set until reset.
- **Reset mid-flush.** Assert `rst_core` asynchronously between edges during FLUSH.
  - Required: `flush_req`, `flush_busy` and `flush_target` go to 0 without a clock edge.
  - After deassertion, a new request is accepted in the first cycle.

Source files
------------

// File: rtl/hsv_core_flush_seq_if.sv
// hsv_core_flush_seq_if: redirect request channel and pipeline flush broadcast/ack bundle
interface hsv_core_flush_seq_if #(parameter int NUM_ACKS = 8);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0][31:0] req_target;
  logic [NUM_ACKS-1:0] flush_ack;
  logic flush_req;
  logic [31:0] flush_target;
  logic flush_src;
  logic flush_busy;
  logic flush_done;
  logic flush_timeout;
  modport master (
    output req_valid, req_target, flush_ack,
    input req_ready, flush_req, flush_target, flush_src, flush_busy, flush_done, flush_timeout
  );
  modport slave (
    input req_valid, req_target, flush_ack,
    output req_ready, flush_req, flush_target, flush_src, flush_busy, flush_done, flush_timeout
  );
endinterface

// File: rtl/hsv_core_flush_seq.sv
// hsv_core_flush_seq: prioritized redirect intake, pipeline-wide flush broadcast and ack collection
module hsv_core_flush_seq #(
  parameter int NUM_ACKS = 8,
  parameter int TIMEOUT = 1024
) (
  input logic clk_core,
  input logic rst_core,
  hsv_core_flush_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic [NUM_ACKS-1:0] ack_mask;
  logic [15:0] cnt;
  logic [1:0] ready;
  logic take0, take1, complete;
  assign bus.req_ready = ready;
  always_comb begin
    ready = state == IDLE ? {~bus.req_valid[0], 1'b1} : {1'b0, state == FLUSH && bus.flush_src};
    take0 = bus.req_valid[0] && ready[0];
    take1 = bus.req_valid[1] && ready[1];
    // a trap preempting a redirect discards this cycle's acks, so it can never complete here
    complete = state == FLUSH && !take0 && &(ack_mask | bus.flush_ack);
    state_n = state == IDLE ? (take0 || take1 ? FLUSH : IDLE)
            : state == FLUSH ? (complete ? DONE : FLUSH) : IDLE;
  end
  always_ff @(posedge clk_core or posedge rst_core)
    if (rst_core) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      bus.flush_req <= 1'b0;
      bus.flush_busy <= 1'b0;
      bus.flush_done <= 1'b0;
      bus.flush_target <= '0;
      bus.flush_src <= 1'b0;
      bus.flush_timeout <= 1'b0;
      ack_mask <= '0;
      cnt <= '0;
    end else begin
      bus.flush_req <= state_n == FLUSH;
      bus.flush_busy <= state_n != IDLE;
      bus.flush_done <= state_n == DONE;
      if (take0 || take1) begin
        bus.flush_target <= take0 ? bus.req_target[0] : bus.req_target[1];
        bus.flush_src <= !take0;
        ack_mask <= '0;
        cnt <= '0;
      end else if (state == FLUSH) begin
        ack_mask <= ack_mask | bus.flush_ack;
        cnt <= &cnt ? cnt : cnt + 16'd1;
        if (!complete && cnt >= LIMIT) bus.flush_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hsv_core_flush_seq.sv
// tb_hsv_core_flush_seq: directed and random stimulus checked against a cycle-level reference model
module tb_hsv_core_flush_seq;
  localparam int N = 8;
  localparam int TO = 8;
  logic clk_core = 1'b0;
  logic rst_core = 1'b1;
  always #5 clk_core = ~clk_core;
  hsv_core_flush_seq_if #(.NUM_ACKS(N)) bus();
  hsv_core_flush_seq #(.NUM_ACKS(N), .TIMEOUT(TO)) dut (.clk_core(clk_core), .rst_core(rst_core), .bus(bus));
  int errors = 0;
  int checks = 0;
  bit m_active, m_done, m_src, m_to;
  logic [31:0] m_target;
  logic [N-1:0] m_seen;
  int m_age;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_active = 0; m_done = 0; m_src = 0; m_to = 0; m_target = '0; m_seen = '0; m_age = 0;
  endtask
  function automatic logic [1:0] m_ready(input logic [1:0] v);
    if (m_done) return 2'b00;
    if (!m_active) return {~v[0], 1'b1};
    return m_src ? 2'b01 : 2'b00;
  endfunction
  task automatic check_outs();
    check("flush_req", 32'(bus.flush_req), 32'(m_active));
    check("flush_busy", 32'(bus.flush_busy), 32'(m_active | m_done));
    check("flush_done", 32'(bus.flush_done), 32'(m_done));
    check("flush_src", 32'(bus.flush_src), 32'(m_src));
    check("flush_target", bus.flush_target, m_target);
    check("flush_timeout", 32'(bus.flush_timeout), 32'(m_to));
  endtask
  task automatic step(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1, input logic [N-1:0] a);
    logic [1:0] r;
    logic take0, take1;
    bus.req_valid = v; bus.req_target[0] = t0; bus.req_target[1] = t1; bus.flush_ack = a;
    #1;
    r = m_ready(v);
    check("req_ready", 32'(bus.req_ready), 32'(r));
    take0 = v[0] & r[0];
    take1 = v[1] & r[1];
    @(posedge clk_core);
    if (m_done) m_done = 0;
    else if (!m_active) begin
      if (take0 | take1) begin
        m_active = 1; m_src = !take0; m_target = take0 ? t0 : t1; m_seen = '0; m_age = 0;
      end
    end else if (take0) begin
      m_src = 0; m_target = t0; m_seen = '0; m_age = 0;
    end else if (&(m_seen | a)) begin
      m_active = 0; m_done = 1;
    end else begin
      if (m_age >= TO - 1) m_to = 1;
      if (m_age < 65535) m_age++;
      m_seen |= a;
    end
    #1;
    check_outs();
  endtask
  task automatic async_reset();
    bus.req_valid = 2'b00;
    bus.flush_ack = '0;
    #2 rst_core = 1'b1;
    #1;
    check("rst_flush_req", 32'(bus.flush_req), 32'd0);
    check("rst_flush_busy", 32'(bus.flush_busy), 32'd0);
    check("rst_flush_target", bus.flush_target, 32'd0);
    check("rst_flush_timeout", 32'(bus.flush_timeout), 32'd0);
    m_reset();
    #2 rst_core = 1'b0;
  endtask
  initial begin
    m_reset();
    bus.req_valid = 2'b00; bus.req_target[0] = '0; bus.req_target[1] = '0; bus.flush_ack = '0;
    repeat (2) @(posedge clk_core);
    #1;
    check_outs();
    rst_core = 1'b0;
    // basic flush: accept, one idle FLUSH cycle, then single ack pulses
    step(2'b10, 32'h0, 32'h0000_1000, '0);
    step(2'b00, 32'h0, 32'h0, '0);
    for (int i = 0; i < N; i++) step(2'b00, 32'h0, 32'h0, N'(1) << i);
    check("basic_done", 32'(bus.flush_done), 32'd1);
    step(2'b00, 32'h0, 32'h0, '0);
    // priority: trap wins, redirect waits for the first IDLE after completion
    step(2'b11, 32'h8000_0000, 32'h2000, '0);
    check("prio_src", 32'(bus.flush_src), 32'd0);
    check("prio_target", bus.flush_target, 32'h8000_0000);
    step(2'b10, 32'h0, 32'h2000, '1);
    step(2'b10, 32'h0, 32'h2000, '0);
    step(2'b10, 32'h0, 32'h2000, '0);
    check("prio_pending_src", 32'(bus.flush_src), 32'd1);
    // preemption of the redirect by a trap, with that cycle's acks discarded
    for (int i = 0; i < 4; i++) step(2'b00, 32'h0, 32'h0, N'(1) << i);
    step(2'b01, 32'h8000_0004, 32'h0, '1);
    check("preempt_target", bus.flush_target, 32'h8000_0004);
    check("preempt_req", 32'(bus.flush_req), 32'd1);
    for (int i = 4; i < N; i++) step(2'b00, 32'h0, 32'h0, N'(1) << i);
    check("preempt_partial", 32'(bus.flush_done), 32'd0);
    step(2'b00, 32'h0, 32'h0, 8'h0F);
    check("preempt_done", 32'(bus.flush_done), 32'd1);
    // acks held high across IDLE and DONE
    step(2'b00, 32'h0, 32'h0, '1);
    step(2'b00, 32'h0, 32'h0, '1);
    step(2'b10, 32'h0, 32'h3000, '1);
    step(2'b00, 32'h0, 32'h0, '1);
    check("fast_done", 32'(bus.flush_done), 32'd1);
    step(2'b00, 32'h0, 32'h0, '1);
    // timeout with ack 7 withheld, then a late ack
    async_reset();
    step(2'b01, 32'h100, 32'h0, '0);
    for (int i = 0; i < 12; i++) step(2'b00, 32'h0, 32'h0, 8'h7F);
    check("timeout_set", 32'(bus.flush_timeout), 32'd1);
    step(2'b00, 32'h0, 32'h0, 8'h80);
    check("timeout_late_done", 32'(bus.flush_done), 32'd1);
    repeat (3) step(2'b00, 32'h0, 32'h0, '0);
    check("timeout_sticky", 32'(bus.flush_timeout), 32'd1);
    // reset in the middle of a flush, then an immediate new request
    step(2'b10, 32'h0, 32'h4000, '0);
    step(2'b00, 32'h0, 32'h0, 8'h03);
    async_reset();
    step(2'b10, 32'h0, 32'h5000, '0);
    check("post_reset_accept", 32'(bus.flush_req), 32'd1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      step(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, $urandom, $urandom, N'($urandom | $urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
